// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the 4-bit ALU and its execution unit.
//   DATA_W      datapath width
//   OP_*        4-bit opcodes (0x0-0xB ALU ops, 0xC LOADI, 0xD-0xF illegal)
//   state_t     execution-unit FSM states
package alu_pkg;

    localparam int DATA_W = 4;

    localparam logic [3:0] OP_NOT   = 4'h0;
    localparam logic [3:0] OP_AND   = 4'h1;
    localparam logic [3:0] OP_NAND  = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_NOR   = 4'h4;
    localparam logic [3:0] OP_XOR   = 4'h5;
    localparam logic [3:0] OP_XNOR  = 4'h6;
    localparam logic [3:0] OP_SHIFT = 4'h7;
    localparam logic [3:0] OP_ADD   = 4'h8;
    localparam logic [3:0] OP_SUB   = 4'h9;
    localparam logic [3:0] OP_MUL   = 4'hA;
    localparam logic [3:0] OP_DIV   = 4'hB;
    localparam logic [3:0] OP_LOADI = 4'hC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB2  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_exec_if.sv
// alu_exec_if: instruction handshake, completion and debug-read bundle of alu_exec.
//   master: instruction source (drives in_*, rd_addr; observes in_ready, done, err, rd_data)
//   slave : alu_exec itself
interface alu_exec_if #(parameter int NREG = 4);
    import alu_pkg::*;

    localparam int AW = $clog2(NREG);

    logic                in_valid;
    logic                in_ready;
    logic [3:0]          in_op;
    logic [AW-1:0]       in_rd;
    logic [AW-1:0]       in_rs1;
    logic [AW-1:0]       in_rs2;
    logic [DATA_W-1:0]   in_imm;
    logic                done;
    logic                err;
    logic [AW-1:0]       rd_addr;
    logic [DATA_W-1:0]   rd_data;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, rd_addr,
        input  in_ready, done, err, rd_data
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, rd_addr,
        output in_ready, done, err, rd_data
    );

endinterface

// File: rtl/alu.sv
// alu: combinational 4-bit ALU.
//   x, y       operands
//   opcode     operation select (OP_NOT..OP_DIV)
//   o          primary result (MUL: low nibble of product, DIV: quotient)
//   product    full 8-bit x*y
//   remainder  x % y for DIV (0 when y == 0 or not DIV)
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0]   x,
    input  logic [DATA_W-1:0]   y,
    input  logic [3:0]          opcode,
    output logic [DATA_W-1:0]   o,
    output logic [2*DATA_W-1:0] product,
    output logic [DATA_W-1:0]   remainder
);

    // Full-width product, independent of opcode.
    assign product = {{DATA_W{1'b0}}, x} * {{DATA_W{1'b0}}, y};

    // Result and remainder selection by opcode.
    always_comb begin
        o         = {DATA_W{1'b0}};
        remainder = {DATA_W{1'b0}};
        case (opcode)
            OP_NOT:   o = ~x;
            OP_AND:   o = x & y;
            OP_NAND:  o = ~(x & y);
            OP_OR:    o = x | y;
            OP_NOR:   o = ~(x | y);
            OP_XOR:   o = x ^ y;
            OP_XNOR:  o = ~(x ^ y);
            // Logical left shift by the low two bits of y.
            OP_SHIFT: o = x << y[1:0];
            OP_ADD:   o = x + y;
            OP_SUB:   o = x - y;
            OP_MUL:   o = product[DATA_W-1:0];
            OP_DIV: begin
                if (y != {DATA_W{1'b0}}) begin
                    o         = x / y;
                    remainder = x % y;
                end else begin
                    o         = {DATA_W{1'b0}};
                    remainder = {DATA_W{1'b0}};
                end
            end
            default:  o = {DATA_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// alu_exec: sequential execution unit around the 4-bit alu.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  alu_exec_if.slave: valid/ready instruction input, done/err
//        completion pulses, combinational debug read of the register file
// One instruction at a time: IDLE -> EXEC (first write) -> [WB2 (second
// write for MUL / DIV)] -> IDLE. Operands are snapshotted at accept.
module alu_exec
    import alu_pkg::*;
#(
    parameter int NREG = 4
)
(
    input  logic         clk,
    input  logic         rst,
    alu_exec_if.slave    bus
);

    localparam int AW = $clog2(NREG);

    state_t              state_r;
    logic                ready_r;
    logic                done_r;
    logic                err_r;
    logic [3:0]          op_r;
    logic [AW-1:0]       rd_r;
    logic [DATA_W-1:0]   imm_r;
    logic [DATA_W-1:0]   x_r;
    logic [DATA_W-1:0]   y_r;
    logic [DATA_W-1:0]   regs_r [NREG];

    logic [DATA_W-1:0]   alu_o_s;
    logic [2*DATA_W-1:0] alu_product_s;
    logic [DATA_W-1:0]   alu_rem_s;
    logic [AW-1:0]       rd_next_s;

    // Second destination wraps naturally because NREG is a power of two.
    assign rd_next_s = rd_r + AW'(1);

    alu u_alu (
        .x         (x_r),
        .y         (y_r),
        .opcode    (op_r),
        .o         (alu_o_s),
        .product   (alu_product_s),
        .remainder (alu_rem_s)
    );

    assign bus.in_ready = ready_r;
    assign bus.done     = done_r;
    assign bus.err      = err_r;
    assign bus.rd_data  = regs_r[bus.rd_addr];

    // Control FSM, operand snapshot and register-file writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            op_r    <= 4'h0;
            rd_r    <= {AW{1'b0}};
            imm_r   <= {DATA_W{1'b0}};
            x_r     <= {DATA_W{1'b0}};
            y_r     <= {DATA_W{1'b0}};
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    err_r  <= 1'b0;
                    if (bus.in_valid) begin
                        state_r <= EXEC;
                        ready_r <= 1'b0;
                        op_r    <= bus.in_op;
                        rd_r    <= bus.in_rd;
                        imm_r   <= bus.in_imm;
                        x_r     <= regs_r[bus.in_rs1];
                        y_r     <= regs_r[bus.in_rs2];
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    case (op_r)
                        OP_NOT, OP_AND, OP_NAND, OP_OR, OP_NOR,
                        OP_XOR, OP_XNOR, OP_SHIFT, OP_ADD, OP_SUB: begin
                            regs_r[rd_r] <= alu_o_s;
                            state_r      <= IDLE;
                            ready_r      <= 1'b1;
                            done_r       <= 1'b1;
                        end
                        OP_LOADI: begin
                            regs_r[rd_r] <= imm_r;
                            state_r      <= IDLE;
                            ready_r      <= 1'b1;
                            done_r       <= 1'b1;
                        end
                        OP_MUL: begin
                            regs_r[rd_r] <= alu_product_s[DATA_W-1:0];
                            state_r      <= WB2;
                        end
                        OP_DIV: begin
                            if (y_r != {DATA_W{1'b0}}) begin
                                regs_r[rd_r] <= alu_o_s;
                                state_r      <= WB2;
                            end else begin
                                // Divide by zero: reject without writing.
                                state_r <= IDLE;
                                ready_r <= 1'b1;
                                done_r  <= 1'b1;
                                err_r   <= 1'b1;
                            end
                        end
                        default: begin
                            // Illegal opcode: reject without writing.
                            state_r <= IDLE;
                            ready_r <= 1'b1;
                            done_r  <= 1'b1;
                            err_r   <= 1'b1;
                        end
                    endcase
                end
                WB2: begin
                    if (op_r == OP_MUL) begin
                        regs_r[rd_next_s] <= alu_product_s[2*DATA_W-1:DATA_W];
                    end else begin
                        regs_r[rd_next_s] <= alu_rem_s;
                    end
                    state_r <= IDLE;
                    ready_r <= 1'b1;
                    done_r  <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b1;
                    done_r  <= 1'b0;
                    err_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed self-checking bench for alu_exec (NREG = 4).
module tb_alu_exec;
    import alu_pkg::*;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    alu_exec_if #(.NREG(4)) bus ();

    alu_exec #(.NREG(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [1:0] idx, input logic [3:0] exp);
        bus.rd_addr = idx;
        #1;
        check_val(tag, {28'h0, bus.rd_data}, {28'h0, exp});
    endtask

    task automatic check_all(input string tag, input logic [3:0] e0, input logic [3:0] e1,
                             input logic [3:0] e2, input logic [3:0] e3);
        check_reg({tag, ":r0"}, 2'd0, e0);
        check_reg({tag, ":r1"}, 2'd1, e1);
        check_reg({tag, ":r2"}, 2'd2, e2);
        check_reg({tag, ":r3"}, 2'd3, e3);
    endtask

    // Wait (bounded) at negedges until the unit is ready.
    task automatic wait_ready(input string tag);
        int k;
        k = 0;
        while (!bus.in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bus.in_ready) check_val({tag, ":ready_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic drive(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic [3:0] imm);
        bus.in_op  = op;
        bus.in_rd  = rd;
        bus.in_rs1 = rs1;
        bus.in_rs2 = rs2;
        bus.in_imm = imm;
    endtask

    // Issue one instruction; exp_lat counts negedges after the accept edge
    // until done is first seen (2 for single-result, 3 for MUL/DIV).
    task automatic run_instr(input string tag, input logic [3:0] op, input logic [1:0] rd,
                             input logic [1:0] rs1, input logic [1:0] rs2,
                             input logic [3:0] imm, input int exp_lat, input logic exp_err);
        int seen;
        int pulses;
        wait_ready(tag);
        drive(op, rd, rs1, rs2, imm);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        seen   = 0;
        pulses = 0;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (n < exp_lat) check_val({tag, ":busy"}, {31'h0, bus.in_ready}, 32'd0);
            if (n == exp_lat) check_val({tag, ":ready_back"}, {31'h0, bus.in_ready}, 32'd1);
            if (bus.done) begin
                pulses++;
                if (seen == 0) begin
                    seen = n;
                    check_val({tag, ":err"}, {31'h0, bus.err}, {31'h0, exp_err});
                end
            end
        end
        check_val({tag, ":lat"}, seen, exp_lat);
        check_val({tag, ":pulses"}, pulses, 32'd1);
    endtask

    initial begin
        int pulses;
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.rd_addr  = 2'd0;
        drive(4'h0, 2'd0, 2'd0, 2'd0, 4'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check_val("rst:in_ready", {31'h0, bus.in_ready}, 32'd1);
        check_val("rst:done",     {31'h0, bus.done},     32'd0);
        check_val("rst:err",      {31'h0, bus.err},      32'd0);
        check_all("rst", 4'h0, 4'h0, 4'h0, 4'h0);

        // LOADI / ADD
        run_instr("ldi_r0", OP_LOADI, 2'd0, 2'd0, 2'd0, 4'h5, 2, 1'b0);
        run_instr("ldi_r1", OP_LOADI, 2'd1, 2'd0, 2'd0, 4'h3, 2, 1'b0);
        run_instr("add",    OP_ADD,   2'd2, 2'd0, 2'd1, 4'h0, 2, 1'b0);
        check_all("add", 4'h5, 4'h3, 4'h8, 4'h0);

        // MUL 5*5 = 0x19
        run_instr("mul", OP_MUL, 2'd2, 2'd0, 2'd0, 4'h0, 3, 1'b0);
        check_all("mul", 4'h5, 4'h3, 4'h9, 4'h1);

        // DIV 15/4 = 3 rem 3, remainder wraps into r0
        run_instr("ldi_f", OP_LOADI, 2'd0, 2'd0, 2'd0, 4'hF, 2, 1'b0);
        run_instr("ldi_4", OP_LOADI, 2'd1, 2'd0, 2'd0, 4'h4, 2, 1'b0);
        run_instr("div",   OP_DIV,   2'd3, 2'd0, 2'd1, 4'h0, 3, 1'b0);
        check_all("div", 4'h3, 4'h4, 4'h9, 4'h3);

        // Errors: divide by zero, illegal opcode
        run_instr("ldi_z", OP_LOADI, 2'd2, 2'd0, 2'd0, 4'h0, 2, 1'b0);
        run_instr("div0",  OP_DIV,   2'd1, 2'd0, 2'd2, 4'h0, 2, 1'b1);
        check_all("div0", 4'h3, 4'h4, 4'h0, 4'h3);
        run_instr("ill",   4'hE,     2'd0, 2'd1, 2'd1, 4'h9, 2, 1'b1);
        check_all("ill", 4'h3, 4'h4, 4'h0, 4'h3);
        run_instr("sub0",  OP_SUB,   2'd3, 2'd1, 2'd1, 4'h0, 2, 1'b0);
        check_all("sub0", 4'h3, 4'h4, 4'h0, 4'h0);

        // A few more ALU functions: 3-4 wraps to F, ~4 = B, F^B = 4, 4|B = F
        run_instr("subw", OP_SUB, 2'd2, 2'd0, 2'd1, 4'h0, 2, 1'b0);
        run_instr("not",  OP_NOT, 2'd3, 2'd1, 2'd0, 4'h0, 2, 1'b0);
        run_instr("xor",  OP_XOR, 2'd0, 2'd2, 2'd3, 4'h0, 2, 1'b0);
        run_instr("or",   OP_OR,  2'd1, 2'd0, 2'd3, 4'h0, 2, 1'b0);
        check_all("logic", 4'h4, 4'hF, 4'hF, 4'hB);

        // in_valid held while busy with changing fields; operand hazard 5+5
        run_instr("ldi_5", OP_LOADI, 2'd0, 2'd0, 2'd0, 4'h5, 2, 1'b0);
        wait_ready("hold");
        drive(OP_ADD, 2'd0, 2'd0, 2'd0, 4'h0);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 drive(OP_LOADI, 2'd1, 2'd2, 2'd3, 4'h7);
        @(negedge clk);
        check_val("hold:busy", {31'h0, bus.in_ready}, 32'd0);
        check_val("hold:no_early_done", {31'h0, bus.done}, 32'd0);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        pulses = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check_val("hold:pulses", pulses, 32'd1);
        check_all("hold", 4'hA, 4'hF, 4'hF, 4'hB);

        // Reset during WB2 of MUL (A*A = 0x64)
        wait_ready("rstwb2");
        drive(OP_MUL, 2'd2, 2'd0, 2'd0, 4'h0);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_val("rstwb2:in_ready", {31'h0, bus.in_ready}, 32'd1);
        check_val("rstwb2:done",     {31'h0, bus.done},     32'd0);
        check_all("rstwb2", 4'h0, 4'h0, 4'h0, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check_val("rstwb2:no_done", pulses, 32'd0);
        check_all("rstwb2_after", 4'h0, 4'h0, 4'h0, 4'h0);
        run_instr("post_rst", OP_LOADI, 2'd3, 2'd0, 2'd0, 4'h6, 2, 1'b0);
        check_all("post_rst", 4'h0, 4'h0, 4'h0, 4'h6);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
